// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shared byte-wide data memory behind the Core array.
// Arbitration is round-robin by default. Define MEM_ARB_FIXED_PRIO_EN to
// switch to fixed priority, where the lowest core index wins.
// One access is in flight at a time. Its timing is IDLE -> BUSY x MEM_LATENCY -> RESP.

// Per-core response lane: registered read data plus the completion strobe.
module core_mem_arbiter_lane #(
   parameter int REG_SIZE = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [REG_SIZE-1:0] din,
   input  logic                resp,
   output logic [REG_SIZE-1:0] rd_data,
   output logic                val
);
   // Read data holds until this core's next read completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_data <= '0;
      else if (load) rd_data <= din;
   end

   assign val = resp;
endmodule

module core_mem_arbiter #(
   parameter int CORE_COUNT  = 4,
   parameter int ADDR_SIZE   = 12,
   parameter int REG_SIZE    = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [2*CORE_COUNT-1:0]        enable,
   input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr,
   input  logic [REG_SIZE*CORE_COUNT-1:0] wr_data,
   output logic [REG_SIZE*CORE_COUNT-1:0] rd_data,
   output logic [CORE_COUNT-1:0]          val
);
   localparam int PW    = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
   localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int DEPTH = 1 << ADDR_SIZE;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   typedef struct packed {
      logic                 wr;
      logic [ADDR_SIZE-1:0] addr;
      logic [REG_SIZE-1:0]  data;
   } mreq_t;

   state_t                state, state_nxt;
   mreq_t                 cur;
   logic [PW-1:0]         grant;
   logic [CW-1:0]         cnt;
   logic [CORE_COUNT-1:0] req;
   logic                  pick_vld;
   logic [PW-1:0]         pick_idx;
   logic [PW-1:0]         scan_idx;
   logic                  latch_en;
   logic                  access;
   logic [REG_SIZE-1:0]   mem [DEPTH];
   logic [REG_SIZE-1:0]   mem_rd;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic [PW-1:0]         rr_ptr;
`endif

   // Only codes 01 and 10 request. Idle (00) and reserved (11) do not.
   always_comb begin
      for (int i = 0; i < CORE_COUNT; i++) req[i] = ^enable[2*i +: 2];
   end

   // Pick the winner. The scan runs downward and keeps the last hit, so the
   // first requester in priority order wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int k = CORE_COUNT-1; k >= 0; k--) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         scan_idx = PW'(k);
`else
         scan_idx = PW'((int'(rr_ptr) + k) % CORE_COUNT);
`endif
         if (req[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   // Next-state logic. The FSM samples requests only in IDLE.
   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: if (pick_vld) begin
            latch_en  = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (cnt == '0) begin
            access    = 1'b1;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the granted request and count down the access latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant <= '0;
         cur   <= '0;
         cnt   <= '0;
      end else if (latch_en) begin
         grant     <= pick_idx;
         cur.wr    <= enable[2*pick_idx +: 2] == 2'b10;
         cur.addr  <= addr[ADDR_SIZE*pick_idx +: ADDR_SIZE];
         cur.data  <= wr_data[REG_SIZE*pick_idx +: REG_SIZE];
         cnt       <= CW'(MEM_LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

`ifndef MEM_ARB_FIXED_PRIO_EN
   // After a completion, the core just served drops to lowest priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr <= '0;
      else if (state == RESP)
         rr_ptr <= (grant == PW'(CORE_COUNT - 1)) ? '0 : grant + 1'b1;
   end
`endif

   // Memory array is not reset. A reset during BUSY forces IDLE, so an
   // abandoned write never commits.
   always_ff @(posedge clk) begin
      if (access && cur.wr) mem[cur.addr] <= cur.data;
   end

   assign mem_rd = mem[cur.addr];

   for (genvar i = 0; i < CORE_COUNT; i++) begin : g_lane
      core_mem_arbiter_lane #(.REG_SIZE(REG_SIZE)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .load    (access && !cur.wr && grant == PW'(i)),
         .din     (mem_rd),
         .resp    (state == RESP && grant == PW'(i)),
         .rd_data (rd_data[REG_SIZE*i +: REG_SIZE]),
         .val     (val[i])
      );
   end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (CORE_COUNT=4, MEM_LATENCY=2).
// Round-robin order expectations switch to fixed priority when the
// MEM_ARB_FIXED_PRIO_EN macro is defined.
module tb_core_mem_arbiter;
   logic        clk;
   logic        reset;
   logic [7:0]  enable;
   logic [47:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [3:0]  val;

   int checks = 0;
   int errors = 0;

   core_mem_arbiter #(.CORE_COUNT(4), .ADDR_SIZE(12), .REG_SIZE(8), .MEM_LATENCY(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .val     (val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int c, input logic [1:0] op, input logic [11:0] a, input logic [7:0] d);
      enable[2*c +: 2]   = op;
      addr[12*c +: 12]   = a;
      wr_data[8*c +: 8]  = d;
   endtask

   // Drop all requests in the val cycle and step to the following IDLE cycle.
   task automatic clear_req();
      enable = '0;
      @(posedge clk); #1;
   endtask

   // Count rising edges until val appears. n stays -1 if the budget expires.
   task automatic wait_val(output int n, output logic [3:0] v);
      n = -1;
      v = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (val !== 4'b0) begin
            n = i;
            v = val;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      enable = '0; addr = '0; wr_data = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (val !== 4'b0) begin errors++; $display("FAIL reset_val: got %h expected 0", val); end
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (val !== 4'b0) begin errors++; $display("FAIL reset_idle_val: got %h expected 0", val); end
   endtask

   task automatic test_write_read();
      int n; logic [3:0] v;
      set_req(0, 2'b10, 12'h010, 8'hA5);
      wait_val(n, v);
      checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", n); end
      checks++; if (v !== 4'b0001) begin errors++; $display("FAIL wr_val: got %b expected 0001", v); end
      checks++; if (rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL wr_keeps_rd: got %h expected 00", rd_data[7:0]); end
      clear_req();
      set_req(0, 2'b01, 12'h010, 8'h00);
      wait_val(n, v);
      checks++; if (n !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", n); end
      checks++; if (v !== 4'b0001) begin errors++; $display("FAIL rd_val: got %b expected 0001", v); end
      checks++; if (rd_data[7:0] !== 8'hA5) begin errors++; $display("FAIL rd_data0: got %h expected a5", rd_data[7:0]); end
      clear_req();
   endtask

   task automatic test_round_robin();
      int n; logic [3:0] v;
      int ord_a [4] = '{0, 1, 2, 3};
      int ord_b [4] = '{2, 3, 0, 1};
      logic [3:0] exp_v;
      pulse_reset();
      enable = 8'h55;
      for (int k = 0; k < 4; k++) begin
         wait_val(n, v);
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_v = 4'b0001;
`else
         exp_v = 4'b0001 << ord_a[k];
`endif
         checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_a_spacing[%0d]: got %0d expected %0d", k, n, (k == 0) ? 3 : 4); end
         checks++; if (v !== exp_v) begin errors++; $display("FAIL rr_a_order[%0d]: got %b expected %b", k, v, exp_v); end
      end
      clear_req();
      // A single core1 access moves the pointer to 2.
      set_req(1, 2'b01, 12'h000, 8'h00);
      wait_val(n, v);
      checks++; if (v !== 4'b0010) begin errors++; $display("FAIL rr_solo1: got %b expected 0010", v); end
      clear_req();
      enable = 8'h55;
      for (int k = 0; k < 4; k++) begin
         wait_val(n, v);
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_v = 4'b0001;
`else
         exp_v = 4'b0001 << ord_b[k];
`endif
         checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_b_spacing[%0d]: got %0d expected %0d", k, n, (k == 0) ? 3 : 4); end
         checks++; if (v !== exp_v) begin errors++; $display("FAIL rr_b_order[%0d]: got %b expected %b", k, v, exp_v); end
      end
      clear_req();
   endtask

   task automatic test_cross_core();
      int n; logic [3:0] v;
      pulse_reset();
      set_req(1, 2'b10, 12'hFFF, 8'h3C);
      wait_val(n, v);
      checks++; if (v !== 4'b0010) begin errors++; $display("FAIL xc_wr_val: got %b expected 0010", v); end
      clear_req();
      set_req(2, 2'b01, 12'hFFF, 8'h00);
      wait_val(n, v);
      checks++; if (v !== 4'b0100) begin errors++; $display("FAIL xc_rd_val: got %b expected 0100", v); end
      checks++; if (rd_data[23:16] !== 8'h3C) begin errors++; $display("FAIL xc_rd_data2: got %h expected 3c", rd_data[23:16]); end
      checks++; if (rd_data[15:8] !== 8'h00) begin errors++; $display("FAIL xc_rd_data1: got %h expected 00", rd_data[15:8]); end
      clear_req();
   endtask

   task automatic test_reserved();
      int bad = 0;
      pulse_reset();
      set_req(0, 2'b11, 12'h010, 8'hEE);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (val !== 4'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL reserved_val: got %0d val cycles expected 0", bad); end
      clear_req();
      // The arbiter must still be IDLE and serve a real request at normal latency.
      begin
         int n; logic [3:0] v;
         set_req(0, 2'b01, 12'h010, 8'h00);
         wait_val(n, v);
         checks++; if (n !== 3) begin errors++; $display("FAIL reserved_after_latency: got %0d expected 3", n); end
         checks++; if (rd_data[7:0] !== 8'hA5) begin errors++; $display("FAIL reserved_after_data: got %h expected a5", rd_data[7:0]); end
         clear_req();
      end
   endtask

   task automatic test_reset_mid_busy();
      int n; logic [3:0] v; int bad = 0;
      set_req(3, 2'b10, 12'h020, 8'h11);
      wait_val(n, v);
      checks++; if (v !== 4'b1000) begin errors++; $display("FAIL rmb_pre_val: got %b expected 1000", v); end
      clear_req();
      set_req(3, 2'b10, 12'h020, 8'h77);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (val !== 4'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rmb_val_in_reset: got %0d val cycles expected 0", bad); end
      enable = '0;
      reset = 1'b1;
      #1;
      checks++; if (val !== 4'b0) begin errors++; $display("FAIL rmb_release_val: got %b expected 0", val); end
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rmb_release_rd: got %h expected 0", rd_data); end
      @(posedge clk); #1;
      set_req(3, 2'b01, 12'h020, 8'h00);
      wait_val(n, v);
      checks++; if (v !== 4'b1000) begin errors++; $display("FAIL rmb_rd_val: got %b expected 1000", v); end
      checks++; if (rd_data[31:24] !== 8'h11) begin errors++; $display("FAIL rmb_mem_kept: got %h expected 11", rd_data[31:24]); end
      clear_req();
   endtask

   task automatic test_latch();
      int n; logic [3:0] v;
      set_req(0, 2'b10, 12'h031, 8'h00);
      wait_val(n, v);
      clear_req();
      set_req(0, 2'b10, 12'h030, 8'h5A);
      @(posedge clk); #1;
      set_req(0, 2'b10, 12'h031, 8'hFF);
      wait_val(n, v);
      checks++; if (n !== 2) begin errors++; $display("FAIL latch_wr_remaining: got %0d expected 2", n); end
      checks++; if (v !== 4'b0001) begin errors++; $display("FAIL latch_wr_val: got %b expected 0001", v); end
      clear_req();
      set_req(0, 2'b01, 12'h030, 8'h00);
      @(posedge clk); #1;
      set_req(0, 2'b01, 12'h031, 8'h00);
      wait_val(n, v);
      checks++; if (rd_data[7:0] !== 8'h5A) begin errors++; $display("FAIL latch_rd_030: got %h expected 5a", rd_data[7:0]); end
      clear_req();
      set_req(0, 2'b01, 12'h031, 8'h00);
      wait_val(n, v);
      checks++; if (rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL latch_rd_031: got %h expected 00", rd_data[7:0]); end
      clear_req();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_cross_core();
      test_reserved();
      test_reset_mid_busy();
      test_latch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
